// File: rtl/impl_print_uart_tx.sv
// impl_print_uart_tx: turns the print peripheral's byte strobes into 8N1 UART
// frames. Bytes are queued in a small FIFO. There is no backpressure toward
// the core: a byte that arrives while the FIFO is full is dropped, and
// overflow_o is set and stays set until reset.
//
// Handshake: print_valid_i is a one-cycle push strobe with no ready. The byte
// is accepted when the FIFO is not full, or when a pop happens in the same
// cycle. A pop happens whenever the FSM is ready for a new byte (IDLE, or the
// last cycle of a stop bit) and the FIFO is non-empty. The FSM only sees
// bytes that are already registered in the FIFO, so there is no fall-through.
module impl_print_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [31:0]                   print_wdata_i,
    input  logic                          print_valid_i,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // FSM state is kept as a plainly named register so checkers can bind to it.
    state_t          state;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW:0]     wptr;
    logic [AW:0]     rptr;
    logic [AW:0]     level;
    logic [AW:0]     level_next;
    logic            fifo_empty;
    logic            fifo_full;
    logic            baud_done;
    logic            pop;
    logic            push_acc;
    logic            push_drop;
    logic            idle_next;
    logic            unused_upper_bits;

    // Only the low byte of the print word carries character data.
    assign unused_upper_bits = ^print_wdata_i[31:8];

    // Pointers are one bit wider than the index, so full and empty can be told apart.
    assign level      = wptr - rptr;
    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign baud_done  = (baud_cnt == '0);

    // Pop when the FSM can start a new frame: from IDLE, or at the end of a stop bit.
    assign pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_done));
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
    assign push_acc   = print_valid_i && (!fifo_full || pop);
    assign push_drop  = print_valid_i && fifo_full && !pop;
    assign idle_next  = ((state == IDLE) || ((state == STOP) && baud_done)) && !pop;
    assign level_next = level + (AW+1)'(push_acc) - (AW+1)'(pop);

    assign fifo_level_o = level;

    // FIFO storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push_acc) begin
            mem[wptr[AW-1:0]] <= print_wdata_i[7:0];
        end
    end

    // Read and write pointers; both wrap naturally modulo 2*FIFO_DEPTH.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_acc) wptr <= wptr + (AW+1)'(1);
            if (pop)      rptr <= rptr + (AW+1)'(1);
        end
    end

    // Sticky overflow flag: set when a byte is dropped, cleared only by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o <= 1'b0;
        end else if (push_drop) begin
            overflow_o <= 1'b1;
        end
    end

    // busy_o is registered from next-cycle values, so it lines up with state and level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_o <= 1'b0;
        end else begin
            busy_o <= !idle_next || (level_next != '0);
        end
    end

    // Frame sequencer with registered tx_o: IDLE -> START -> DATA x8 -> STOP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_o     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx_o <= 1'b1;
                    if (pop) begin
                        shift    <= mem[rptr[AW-1:0]];
                        baud_cnt <= BAUD_RELOAD;
                        state    <= START;
                        tx_o     <= 1'b0;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_cnt <= BAUD_RELOAD;
                        bit_idx  <= '0;
                        tx_o     <= shift[0];
                        shift    <= shift >> 1;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= BAUD_RELOAD;
                        if (bit_idx == 3'd7) begin
                            tx_o  <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_o    <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        if (pop) begin
                            // Next byte is waiting: go straight into its start bit.
                            shift    <= mem[rptr[AW-1:0]];
                            baud_cnt <= BAUD_RELOAD;
                            tx_o     <= 1'b0;
                            state    <= START;
                        end else begin
                            tx_o  <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
                default: begin
                    tx_o  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
